// File: rtl/iobuf_pkg.sv
// ---------------------------------------------------------------------------
// iobuf_pkg
// Shared definitions for the registered bidirectional pad bank.
//   - iobuf_state_e : direction controller states
//   - CNT_W         : width of the turnaround down-counter
//   - MAX_TURN_CYC  : largest turnaround length the counter can hold
// ---------------------------------------------------------------------------
package iobuf_pkg;

  localparam int CNT_W        = 4;
  localparam int MAX_TURN_CYC = 15;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    TA_TX = 2'd1,
    DRIVE = 2'd2,
    TA_RX = 2'd3
  } iobuf_state_e;

endpackage

// File: rtl/iobuf_in_sync.sv
// ---------------------------------------------------------------------------
// iobuf_in_sync
// Input capture path of the pad bank. Samples the pads through a DEPTH-stage
// flop chain (DEPTH=1 plain capture, DEPTH=2 synchroniser) and delays the
// "bank is receiving" flag by the same number of stages so that valid_o
// always describes the sample currently on data_o.
// Ports:
//   clk      bank clock
//   reset_n  asynchronous active-low reset
//   pad_i    raw pad values
//   recv_i   high while the controller sits in the receive state
//   data_o   registered pad sample
//   valid_o  data_o was sampled while the bank was receiving
// ---------------------------------------------------------------------------
module iobuf_in_sync
  import iobuf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic             recv_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] dataPipe_q [DEPTH];
  logic [DEPTH-1:0] validPipe_q;

  // Data and valid travel through matching stages so they never skew.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        dataPipe_q[k] <= '0;
      end
      validPipe_q <= '0;
    end else begin
      dataPipe_q[0]  <= pad_i;
      validPipe_q[0] <= recv_i;
      for (int k = 1; k < DEPTH; k++) begin
        dataPipe_q[k]  <= dataPipe_q[k-1];
        validPipe_q[k] <= validPipe_q[k-1];
      end
    end
  end

  assign data_o  = dataPipe_q[DEPTH-1];
  assign valid_o = validPipe_q[DEPTH-1];

endmodule

// File: rtl/iobuf_bank_ta.sv
// ---------------------------------------------------------------------------
// iobuf_bank_ta
// Registered bidirectional pad bank with a turnaround controller. Every
// change of direction passes through TURN_CYC cycles with all pads high-Z so
// the bank and the external device are never driving at the same time.
// Ports:
//   clk      bank clock (rising edge)
//   reset_n  asynchronous active-low reset; releases the pads at once
//   dir_req  1 = request drive mode, 0 = request receive mode
//   dir_ack  bank is settled in the requested direction
//   busy     turnaround in progress
//   i_data   data to drive onto the pads
//   i_load   load i_data into the output register (any state)
//   io_pad   the pads
//   o_data   registered pad sample
//   o_valid  o_data was sampled in receive mode
// Build option:
//   IOBUF_BANK_SYNC2_EN  when defined, the input path is a 2-flop
//                        synchroniser (o_data/o_valid latency 2 instead of 1)
// ---------------------------------------------------------------------------
module iobuf_bank_ta
  import iobuf_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               TURN_CYC  = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dir_req,
  output logic             dir_ack,
  output logic             busy,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load,
  inout  wire  [WIDTH-1:0] io_pad,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

`ifdef IOBUF_BANK_SYNC2_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  // The counter starts at TURN_CYC-1 and the exit happens on the edge that
  // sees zero, giving exactly TURN_CYC idle cycles.
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

  iobuf_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             oe_q;
  logic [WIDTH-1:0] outReg_q;

  // Direction controller. oe_q is kept as its own flop, set on the edge that
  // enters DRIVE and cleared on the edge that leaves it, so the pad enable
  // comes straight from a register with no decode glitches. A dir_req change
  // during a turnaround is simply not looked at until the turnaround ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RECV;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      unique case (state_q)
        RECV: begin
          if (dir_req) begin
            state_q <= TA_TX;
            cnt_q   <= TURN_LOAD;
          end
        end
        TA_TX: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= DRIVE;
            oe_q    <= 1'b1;
          end
        end
        DRIVE: begin
          if (!dir_req) begin
            state_q <= TA_RX;
            cnt_q   <= TURN_LOAD;
            oe_q    <= 1'b0;
          end
        end
        TA_RX: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= RECV;
          end
        end
      endcase
    end
  end

  // Output data register; loadable in every state so the core can preload
  // data before requesting drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outReg_q <= RESET_VAL;
    end else if (i_load) begin
      outReg_q <= i_data;
    end
  end

  assign io_pad = oe_q ? outReg_q : 'z;

  assign busy    = (state_q == TA_TX) || (state_q == TA_RX);
  assign dir_ack = ((state_q == DRIVE) && dir_req) ||
                   ((state_q == RECV) && !dir_req);

  iobuf_in_sync #(
    .WIDTH (WIDTH),
    .DEPTH (SYNC_DEPTH)
  ) u_in_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pad_i   (io_pad),
    .recv_i  (state_q == RECV),
    .data_o  (o_data),
    .valid_o (o_valid)
  );

endmodule
